// File: rtl/time_set_ctrl.sv
// Keypad HH:MM entry sequencer for clock/alarm set; every output registered, one cycle after key_valid; no backpressure.
// Define TSC_BLINK_EN to blink the twinkle digit, otherwise blink is held at 1.
module time_set_ctrl #(
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_val,
    output logic [5:0] set_hour,
    output logic [5:0] set_min,
    output logic [2:0] twinkle,
    output logic       target,
    output logic       busy,
    output logic       load_clk,
    output logic       load_alarm,
    output logic       key_err,
    output logic       timeout,
    output logic       blink
);

    // State codes double as the twinkle digit index driven to the display.
    typedef enum logic [2:0] {
        S_HT   = 3'b000,
        S_HU   = 3'b001,
        S_MT   = 3'b010,
        S_MU   = 3'b011,
        S_CONF = 3'b100,
        S_IDLE = 3'b111
    } state_e;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    state_e        state_q, state_d;
    logic [5:0]    hour_q, hour_d, min_q, min_d;
    logic          target_q, target_d, busy_q;
    logic          load_clk_q, load_clk_d, load_alarm_q, load_alarm_d;
    logic          key_err_q, key_err_d, timeout_q, timeout_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [5:0]    dig;

    assign dig = {2'b00, key_val};

    always_comb begin
        state_d      = state_q;
        hour_d       = hour_q;
        min_d        = min_q;
        target_d     = target_q;
        timer_d      = timer_q;
        load_clk_d   = 1'b0;
        load_alarm_d = 1'b0;
        key_err_d    = 1'b0;
        timeout_d    = 1'b0;
        if (state_q == S_IDLE) begin
            timer_d = '0;
            if (key_valid && (key_val == 4'hA || key_val == 4'hB)) begin
                state_d  = S_HT;
                target_d = (key_val == 4'hB);
                hour_d   = '0;
                min_d    = '0;
            end
        end else if (key_valid) begin
            // A key in the expiry cycle takes priority and restarts the timer.
            timer_d = '0;
            if (key_val == 4'hC) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_HT: if (key_val <= 4'd2) begin
                        hour_d  = dig * 6'd10;
                        state_d = S_HU;
                    end else key_err_d = 1'b1;
                    S_HU: if (key_val <= 4'd9 && (hour_q < 6'd20 || key_val <= 4'd3)) begin
                        hour_d  = hour_q + dig;
                        state_d = S_MT;
                    end else key_err_d = 1'b1;
                    S_MT: if (key_val <= 4'd5) begin
                        min_d   = dig * 6'd10;
                        state_d = S_MU;
                    end else key_err_d = 1'b1;
                    S_MU: if (key_val <= 4'd9) begin
                        min_d   = min_q + dig;
                        state_d = S_CONF;
                    end else key_err_d = 1'b1;
                    S_CONF: if (key_val == 4'hD) begin
                        load_clk_d   = ~target_q;
                        load_alarm_d = target_q;
                        state_d      = S_IDLE;
                    end else key_err_d = 1'b1;
                    default: state_d = S_IDLE;
                endcase
            end
        end else if (timer_q == TIMER_LAST) begin
            timeout_d = 1'b1;
            timer_d   = '0;
            state_d   = S_IDLE;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            hour_q       <= '0;
            min_q        <= '0;
            target_q     <= 1'b0;
            busy_q       <= 1'b0;
            timer_q      <= '0;
            load_clk_q   <= 1'b0;
            load_alarm_q <= 1'b0;
            key_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            target_q     <= target_d;
            busy_q       <= (state_d != S_IDLE);
            timer_q      <= timer_d;
            load_clk_q   <= load_clk_d;
            load_alarm_q <= load_alarm_d;
            key_err_q    <= key_err_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef TSC_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    logic [BW-1:0] bcnt_q;
    logic          blink_q;

    // Every accepted key moves the FSM, so a state change restarts the blink phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt_q  <= '0;
            blink_q <= 1'b1;
        end else if (state_d == S_IDLE || state_d != state_q) begin
            bcnt_q  <= '0;
            blink_q <= 1'b1;
        end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_q  <= '0;
            blink_q <= ~blink_q;
        end else begin
            bcnt_q  <= bcnt_q + 1'b1;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b1;
`endif

    assign set_hour   = hour_q;
    assign set_min    = min_q;
    assign twinkle    = state_q;
    assign target     = target_q;
    assign busy       = busy_q;
    assign load_clk   = load_clk_q;
    assign load_alarm = load_alarm_q;
    assign key_err    = key_err_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: keys are driven at negedge and outputs sampled at the following negedge.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_val;
    logic [5:0] set_hour, set_min;
    logic [2:0] twinkle;
    logic       target, busy, load_clk, load_alarm, key_err, timeout, blink;

    int n_tests = 0;
    int n_fail  = 0;

    time_set_ctrl #(.TIMEOUT_CYC(16), .BLINK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_val   (key_val),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .twinkle   (twinkle),
        .target    (target),
        .busy      (busy),
        .load_clk  (load_clk),
        .load_alarm(load_alarm),
        .key_err   (key_err),
        .timeout   (timeout),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; the key is sampled by the next posedge and we return at the negedge after it.
    task automatic press(input logic [3:0] k);
        key_val   = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_val   = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hour"}, set_hour, 0);
        check({tag, "_min"}, set_min, 0);
        check({tag, "_twinkle"}, twinkle, 7);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_target"}, target, 0);
        check({tag, "_pulses"}, {load_clk, load_alarm, key_err, timeout}, 0);
        check({tag, "_blink"}, blink, 1);
    endtask

    initial begin
        rst       = 1'b0;
        key_valid = 1'b0;
        key_val   = 4'h0;
        idle(2);
        check_reset_vals("rst");
        rst = 1'b1;
        idle(1);

        // Clock set 17:45
        press(4'hA); check("a_tw0", twinkle, 0); check("a_busy", busy, 1); check("a_tgt", target, 0);
        press(4'd1); check("a_tw1", twinkle, 1); check("a_h10", set_hour, 10);
        press(4'd7); check("a_tw2", twinkle, 2); check("a_h17", set_hour, 17);
        press(4'd4); check("a_tw3", twinkle, 3); check("a_m40", set_min, 40);
        press(4'd5); check("a_tw4", twinkle, 4); check("a_m45", set_min, 45);
        press(4'hD);
        check("a_ldclk", load_clk, 1); check("a_ldal", load_alarm, 0);
        check("a_busy0", busy, 0); check("a_tw7", twinkle, 7);
        check("a_hour", set_hour, 17); check("a_min", set_min, 45);
        idle(1); check("a_ldclk_1cyc", load_clk, 0);

        // Alarm set with hour-units range check at 20
        press(4'hB); check("b_tgt", target, 1); check("b_h0", set_hour, 0); check("b_m0", set_min, 0);
        press(4'd2); check("b_h20", set_hour, 20);
        press(4'd4); check("b_err4", key_err, 1); check("b_stay_hu", twinkle, 1);
        press(4'd3); check("b_err_clr", key_err, 0); check("b_h23", set_hour, 23);
        press(4'd5);
        press(4'd9); check("b_m59", set_min, 59);
        press(4'hD);
        check("b_ldal", load_alarm, 1); check("b_ldclk", load_clk, 0);
        check("b_hour", set_hour, 23); check("b_min", set_min, 59);
        idle(1); check("b_ldal_1cyc", load_alarm, 0);

        // Tens-digit range checks
        press(4'hA);
        press(4'd3); check("c_err3", key_err, 1); check("c_tw0", twinkle, 0);
        press(4'd0); check("c_h0", set_hour, 0); check("c_tw1", twinkle, 1);
        press(4'd8); check("c_h8", set_hour, 8);
        press(4'd6); check("c_err6", key_err, 1); check("c_tw2", twinkle, 2);
        press(4'hD); check("c_errD", key_err, 1);
        press(4'hB); check("c_errB", key_err, 1); check("c_tgt", target, 0);
        press(4'hC); check("c_cancel", busy, 0); check("c_cancel_noerr", key_err, 0);

        // Cancel mid-entry
        press(4'hA); press(4'd1); press(4'd2); press(4'hC);
        check("d_busy", busy, 0); check("d_tw", twinkle, 7);
        check("d_loads", {load_clk, load_alarm}, 0); check("d_hold12", set_hour, 12);

        // Non-start keys in IDLE are silent
        press(4'd5); check("e_idle_noerr", key_err, 0); check("e_idle_busy", busy, 0);
        press(4'hD); check("e_idle_D", {key_err, load_clk, load_alarm}, 0);

        // Timeout after 16 idle cycles
        press(4'hA); press(4'd1);
        idle(15); check("t_not_yet", timeout, 0); check("t_busy", busy, 1);
        idle(1);  check("t_pulse", timeout, 1); check("t_idle", busy, 0); check("t_tw", twinkle, 7);
        check("t_noload", {load_clk, load_alarm}, 0);
        idle(1);  check("t_1cyc", timeout, 0);

        // Key in the expiry cycle wins and restarts the timer
        press(4'hA); press(4'd1);
        idle(15);
        press(4'd5); check("k_no_to", timeout, 0); check("k_tw2", twinkle, 2); check("k_h15", set_hour, 15);
        idle(15); check("k_busy", busy, 1); check("k_not_yet", timeout, 0);
        idle(1);  check("k_to", timeout, 1);

        // Asynchronous reset while in MU
        press(4'hB); press(4'd1); press(4'd2); press(4'd3);
        check("r_tw3", twinkle, 3);
        key_val   = 4'hD;
        key_valid = 1'b1;
        #1 rst = 1'b0;
        #1 check_reset_vals("r_async");
        idle(1);
        check_reset_vals("r_held");
        key_valid = 1'b0;
        rst       = 1'b1;
        idle(1);
        check("r_after_busy", busy, 0);
        check("r_after_loads", {load_clk, load_alarm}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
